// File: rtl/wishbone_spi_slave_regs.sv
// Wishbone classic register front-end for an SPI master core: TX/RX data,
// CTRL, DIVIDER and SS registers, with go/busy handshake and completion IRQ.
module wishbone_spi_slave_regs #(
  parameter int DIV_W = 16,
  parameter int SS_NB = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               cyc_in,
  input  logic               stb_in,
  input  logic               we_in,
  input  logic [4:0]         addr_in,
  input  logic [3:0]         sel_in,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               ack_out,
  output logic               int_out,
  input  logic               done_in,
  input  logic [127:0]       rx_data_in,
  output logic [127:0]       tx_data_out,
  output logic               go_out,
  output logic [6:0]         char_len_out,
  output logic               rx_neg_out,
  output logic               tx_neg_out,
  output logic               lsb_out,
  output logic               ass_out,
  output logic [DIV_W-1:0]   divider_out,
  output logic [SS_NB-1:0]   ss_out
);

  localparam logic [2:0] W_CTRL = 3'd4;
  localparam logic [2:0] W_DIV  = 3'd5;
  localparam logic [2:0] W_SS   = 3'd6;

  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic                  irq_q, irq_d;
  logic                  go_q, go_d;
  logic [3:0][31:0]      tx_q, tx_d;
  logic [6:0]            len_q, len_d;
  logic                  rxneg_q, rxneg_d;
  logic                  txneg_q, txneg_d;
  logic                  lsb_q, lsb_d;
  logic                  ie_q, ie_d;
  logic                  ass_q, ass_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [SS_NB-1:0]      ss_q, ss_d;

  logic                  access;
  logic                  wr_ok;
  logic                  done_hit;
  logic [2:0]            word;
  logic [31:0]           ctrl_rd;
  logic [31:0]           rd_mux;
  logic [31:0]           ctrl_wr;
  logic [31:0]           div_wr;
  logic [31:0]           ss_wr;
  logic                  unused_bits;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // An access commits only on the edge where ack is low, giving one ack per two cycles.
  assign access   = cyc_in & stb_in & ~ack_q;
  assign wr_ok    = access & we_in & ~go_q;
  assign done_hit = done_in & go_q;
  assign word     = addr_in[4:2];

  assign ctrl_rd = {18'b0, ass_q, ie_q, lsb_q, txneg_q, rxneg_q, go_q, 1'b0, len_q};
  assign ctrl_wr = lane_merge(ctrl_rd, data_in, sel_in);
  assign div_wr  = lane_merge(32'(div_q), data_in, sel_in);
  assign ss_wr   = lane_merge(32'(ss_q), data_in, sel_in);

  assign unused_bits = ^{addr_in[1:0], ctrl_wr[31:14], ctrl_wr[7], div_wr, ss_wr};

  always_comb begin
    rd_mux = 32'b0;
    case (word)
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = rx_data_in[32*word[1:0] +: 32];
      W_CTRL:                 rd_mux = ctrl_rd;
      W_DIV:                  rd_mux = 32'(div_q);
      W_SS:                   rd_mux = 32'(ss_q);
      default:                rd_mux = 32'b0;
    endcase
  end

  always_comb begin
    ack_d   = access;
    dat_d   = (access && !we_in) ? rd_mux : 32'b0;
    irq_d   = irq_q;
    go_d    = go_q;
    tx_d    = tx_q;
    len_d   = len_q;
    rxneg_d = rxneg_q;
    txneg_d = txneg_q;
    lsb_d   = lsb_q;
    ie_d    = ie_q;
    ass_d   = ass_q;
    div_d   = div_q;
    ss_d    = ss_q;

    if (wr_ok) begin
      case (word)
        3'd0, 3'd1, 3'd2, 3'd3: tx_d[word[1:0]] = lane_merge(tx_q[word[1:0]], data_in, sel_in);
        W_CTRL: begin
          // GO is read as 0 here (idle), so a lane-1 write of 0 leaves it clear.
          len_d   = ctrl_wr[6:0];
          go_d    = ctrl_wr[8];
          rxneg_d = ctrl_wr[9];
          txneg_d = ctrl_wr[10];
          lsb_d   = ctrl_wr[11];
          ie_d    = ctrl_wr[12];
          ass_d   = ctrl_wr[13];
        end
        W_DIV:   div_d = div_wr[DIV_W-1:0];
        W_SS:    ss_d  = ss_wr[SS_NB-1:0];
        default: ;
      endcase
    end

    if (done_hit) go_d = 1'b0;

    // A completion on the same edge as an acked access leaves the interrupt set.
    if (done_hit && ie_q) irq_d = 1'b1;
    else if (access)      irq_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'b0;
      irq_q   <= 1'b0;
      go_q    <= 1'b0;
      tx_q    <= '0;
      len_q   <= 7'b0;
      rxneg_q <= 1'b0;
      txneg_q <= 1'b0;
      lsb_q   <= 1'b0;
      ie_q    <= 1'b0;
      ass_q   <= 1'b0;
      div_q   <= '0;
      ss_q    <= '0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
      go_q    <= go_d;
      tx_q    <= tx_d;
      len_q   <= len_d;
      rxneg_q <= rxneg_d;
      txneg_q <= txneg_d;
      lsb_q   <= lsb_d;
      ie_q    <= ie_d;
      ass_q   <= ass_d;
      div_q   <= div_d;
      ss_q    <= ss_d;
    end
  end

  assign ack_out      = ack_q;
  assign data_out     = dat_q;
  assign int_out      = irq_q;
  assign go_out       = go_q;
  assign tx_data_out  = tx_q;
  assign char_len_out = len_q;
  assign rx_neg_out   = rxneg_q;
  assign tx_neg_out   = txneg_q;
  assign lsb_out      = lsb_q;
  assign ass_out      = ass_q;
  assign divider_out  = div_q;
  assign ss_out       = ss_q;

endmodule
